// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencing controller:
// state encoding, default operand width and the bit-counter width helper.
package mult_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      CHECK = 3'd3,
      ADD   = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Counter must hold 0..width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Shift counter for the multiplier controller: synchronous clear, increment,
// terminal count when count == WIDTH. Saturates at WIDTH instead of wrapping.
module mult_bit_counter
   import mult_pkg::*;
#(
   parameter int  WIDTH = DEF_WIDTH,
   localparam int CW    = cnt_width(WIDTH)
)(
   input  logic          Clk,
   input  logic          Reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          tc
);

   assign tc = (count == CW'(WIDTH));

   // Count register; clear wins over increment.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !tc) begin
         count <= count + CW'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the shift-add multiplier accumulator (Load/Ad/Sh
// strobes, Busy/Done). Define MULT_SEQ_CTRL_ABORT_EN to add the Abort input.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   input  logic M,
`ifdef MULT_SEQ_CTRL_ABORT_EN
   input  logic Abort,
`endif
   output logic Load,
   output logic Ad,
   output logic Sh,
   output logic Busy,
   output logic Done
);

   localparam int CW = cnt_width(WIDTH);

   state_t        state_r;
   state_t        next_state_s;
   logic [CW-1:0] count_s;
   logic          tc_s;
   logic          clr_s;
   logic          inc_s;
   logic          abort_s;
   logic          last_shift_s;

`ifdef MULT_SEQ_CTRL_ABORT_EN
   assign abort_s = Abort && (state_r inside {LOAD, SHIFT, CHECK, ADD});
`else
   assign abort_s = 1'b0;
`endif

   assign clr_s        = (state_r == LOAD) || abort_s;
   assign inc_s        = (state_r == SHIFT);
   // The shift in progress is the final one when WIDTH-1 shifts are already counted.
   assign last_shift_s = (count_s == CW'(WIDTH - 1));

   mult_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (clr_s),
      .inc   (inc_s),
      .count (count_s),
      .tc    (tc_s)
   );

   // Next-state logic; bit 0 is added during LOAD so LOAD goes straight to SHIFT.
   always_comb begin
      next_state_s = state_r;
      if (abort_s) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    if (Start) next_state_s = LOAD; else next_state_s = IDLE;
            LOAD:    next_state_s = SHIFT;
            SHIFT:   if (last_shift_s) next_state_s = DONE; else next_state_s = CHECK;
            CHECK:   if (tc_s) next_state_s = DONE;
                     else if (M) next_state_s = ADD;
                     else next_state_s = SHIFT;
            ADD:     next_state_s = SHIFT;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Outputs registered from the next state so they line up with state_r.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Load <= 1'b0;
         Ad   <= 1'b0;
         Sh   <= 1'b0;
         Busy <= 1'b0;
         Done <= 1'b0;
      end else begin
         Load <= (next_state_s == LOAD);
         Ad   <= (next_state_s == ADD);
         Sh   <= (next_state_s == SHIFT);
         Busy <= (next_state_s inside {LOAD, SHIFT, CHECK, ADD});
         Done <= (next_state_s == DONE);
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl (WIDTH=4) driving a behavioural accumulator;
// the Abort scenario is built only when MULT_SEQ_CTRL_ABORT_EN is defined.
module tb_mult_seq_ctrl;

   localparam int W = 4;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   logic Start = 1'b0;
   logic M;
   logic Load, Ad, Sh, Busy, Done;
`ifdef MULT_SEQ_CTRL_ABORT_EN
   logic Abort = 1'b0;
`endif

   logic [W-1:0] cur_x = '0;
   logic [W-1:0] cur_y = '0;
   logic [2*W:0] acc = '0;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int sh_cnt = 0;
   int ad_cnt = 0;

   typedef struct {
      int x;
      int y;
      int load_cyc;
      int done_cyc;
      int adds;
   } exp_t;
   exp_t q[$];

   mult_seq_ctrl #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .M     (M),
`ifdef MULT_SEQ_CTRL_ABORT_EN
      .Abort (Abort),
`endif
      .Load  (Load),
      .Ad    (Ad),
      .Sh    (Sh),
      .Busy  (Busy),
      .Done  (Done)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Accumulator datapath: bit-0 add folded into the load, then add/shift steps.
   always @(posedge Clk) begin
      if (Load)
         acc <= {1'b0, (cur_x[0] ? cur_y : {W{1'b0}}), cur_x};
      else if (Ad)
         acc[2*W:W] <= {1'b0, acc[2*W-1:W]} + {1'b0, cur_y};
      else if (Sh)
         acc <= {1'b0, acc[2*W:1]};
   end
   assign M = acc[0];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int popcnt_hi(input int x);
      int n = 0;
      for (int i = 1; i < W; i++) n += (x >> i) & 1;
      return n;
   endfunction

   function automatic int push_op(input int x, input int y, input int load_cyc);
      exp_t e;
      e.x = x;
      e.y = y;
      e.load_cyc = load_cyc;
      e.adds = popcnt_hi(x);
      e.done_cyc = load_cyc + 2*W + e.adds;
      q.push_back(e);
      return e.done_cyc;
   endfunction

   // Monitor: compares every strobe/Done event against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         check("strobe_overlap", (int'(Load) + int'(Ad) + int'(Sh) > 1) ? 1 : 0, 0);
         if (Load || Ad || Sh) check("busy_with_strobe", int'(Busy), 1);
         if (Load) begin
            if (q.size() == 0) check("unexpected_load", 1, 0);
            else check("load_cycle", cyc, q[0].load_cyc);
            sh_cnt = 0;
            ad_cnt = 0;
         end
         if (Sh) sh_cnt++;
         if (Ad) ad_cnt++;
         if (Done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("shift_count", sh_cnt, W);
               check("add_count", ad_cnt, e.adds);
               check("busy_at_done", int'(Busy), 0);
               check("product", int'(acc[2*W-1:0]), e.x * e.y);
            end
         end
      end
   end

   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget && q.size() > 0; i++) begin
         @(negedge Clk);
         #2;
      end
      check("op_timeout", q.size(), 0);
      q.delete();
   endtask

   // Called at a negedge with the DUT idle; Start is a single-cycle pulse.
   task automatic run_op(input int x, input int y, input int gap);
      int d;
      cur_x = x[W-1:0];
      cur_y = y[W-1:0];
      Start = 1'b1;
      d = push_op(x & 15, y & 15, cyc + 1);
      @(negedge Clk);
      Start = 1'b0;
      wait_empty(200);
      repeat (1 + gap) @(negedge Clk);
   endtask

   task automatic check_all_low(input string name);
      check({name, "_load"}, int'(Load), 0);
      check({name, "_ad"},   int'(Ad),   0);
      check({name, "_sh"},   int'(Sh),   0);
      check({name, "_busy"}, int'(Busy), 0);
      check({name, "_done"}, int'(Done), 0);
   endtask

   initial begin
      int d;
      int nl;
      int found;

      #2;
      check_all_low("reset");
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);

      run_op(0, 5, 0);
      run_op(15, 15, 0);
      run_op(10, 3, 0);

      // Reset asserted during an ADD cycle, then a clean operation.
      cur_x = 4'b1111;
      cur_y = 4'b0111;
      Start = 1'b1;
      d = push_op(15, 7, cyc + 1);
      @(negedge Clk);
      Start = 1'b0;
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(negedge Clk);
         if (Ad) found = 1;
      end
      check("add_seen_before_reset", found, 1);
      #1 Reset = 1'b0;
      q.delete();
      #1 check_all_low("async_reset");
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      run_op(9, 6, 1);

      // Start held for 20 cycles: accepted only from IDLE.
      cur_x = 4'b0000;
      cur_y = 4'b0011;
      nl = cyc + 1;
      while (nl <= cyc + 20) nl = push_op(0, 3, nl) + 2;
      Start = 1'b1;
      repeat (20) @(negedge Clk);
      Start = 1'b0;
      wait_empty(200);
      @(negedge Clk);

`ifdef MULT_SEQ_CTRL_ABORT_EN
      // Abort while in CHECK: back to IDLE, no Done, next op normal.
      cur_x = 4'b0110;
      cur_y = 4'b0101;
      Start = 1'b1;
      d = push_op(6, 5, cyc + 1);
      @(negedge Clk);
      Start = 1'b0;
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(negedge Clk);
         if (Busy && !Load && !Ad && !Sh) found = 1;
      end
      check("check_state_seen", found, 1);
      Abort = 1'b1;
      q.delete();
      @(negedge Clk);
      Abort = 1'b0;
      check_all_low("after_abort");
      repeat (12) @(negedge Clk);
      run_op(6, 5, 0);
`endif

      for (int n = 0; n < 30; n++) begin
         run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
      end

      repeat (3) @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
